// File: rtl/lcd_update_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_update_sequencer
//
// Pushes one display update (SpO2, heart rate, power) to an LCD register
// block over APB as five writes: three value registers, then a strobe set,
// an optional strobe hold gap, and a strobe clear. A slave error or an
// ACCESS phase that never sees PREADY aborts the sequence and raises the
// sticky err flag.
//
// Parameters
//   ADDR_WIDTH  APB address width
//   DATA_WIDTH  APB data width
//   BASE_ADDR   base address of the LCD register block
//   STB_HOLD    idle cycles between strobe-set and strobe-clear (0..255)
//   TIMEOUT     ACCESS cycles allowed without PREADY (1..255)
//
// Ports
//   clk, resetn          clock (rising edge), async active-low reset
//   upd_valid/upd_ready  update handshake; ready only while idle
//   spo2_in, heart_in,   update payload, captured on acceptance
//   watt_in
//   PADDR..PWDATA        APB requester outputs (PWRITE=1 while PSEL=1)
//   PREADY, PSLVERROR    APB completer responses
//   done                 one-cycle pulse on error-free completion
//   err                  sticky abort flag, cleared by the next acceptance
// ---------------------------------------------------------------------------
module lcd_update_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int unsigned           STB_HOLD   = 4,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [11:0]           spo2_in,
  input  logic [11:0]           heart_in,
  input  logic [19:0]           watt_in,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERROR,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Terminal counts for the shared cycle counter (ACCESS wait / HOLD gap).
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 32'd1);
  localparam logic [7:0] HOLD_LAST = (STB_HOLD != 32'd0) ? 8'(STB_HOLD - 32'd1) : 8'd0;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [7:0]            r_cnt;
  logic [11:0]           r_spo2;
  logic [11:0]           r_heart;
  logic [19:0]           r_watt;
  logic                  r_upd_ready;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_done;
  logic                  r_err;

  state_t                w_state_nxt;
  logic [2:0]            w_idx_nxt;
  logic [7:0]            w_cnt_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic                  w_load;
  logic                  w_accept;
  logic [11:0]           w_spo2_src;
  logic [11:0]           w_heart_src;
  logic [19:0]           w_watt_src;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Register offset of write index 0..4; both strobe writes share 0xC.
  function automatic logic [ADDR_WIDTH-1:0] f_wr_addr(input logic [2:0] idx);
    logic [3:0] off;
    case (idx)
      3'd0:    off = 4'h0;
      3'd1:    off = 4'h4;
      3'd2:    off = 4'h8;
      3'd3:    off = 4'hC;
      3'd4:    off = 4'hC;
      default: off = 4'h0;
    endcase
    return BASE_ADDR + ADDR_WIDTH'(off);
  endfunction

  // Zero-extended write data for write index 0..4.
  function automatic logic [DATA_WIDTH-1:0] f_wr_data(input logic [2:0]  idx,
                                                      input logic [11:0] spo2,
                                                      input logic [11:0] heart,
                                                      input logic [19:0] watt);
    logic [DATA_WIDTH-1:0] d;
    case (idx)
      3'd0:    d = DATA_WIDTH'(spo2);
      3'd1:    d = DATA_WIDTH'(heart);
      3'd2:    d = DATA_WIDTH'(watt);
      3'd3:    d = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      default: d = {DATA_WIDTH{1'b0}};
    endcase
    return d;
  endfunction

  // W0 is loaded in the acceptance cycle, before the shadows hold the payload.
  assign w_spo2_src  = w_accept ? spo2_in  : r_spo2;
  assign w_heart_src = w_accept ? heart_in : r_heart;
  assign w_watt_src  = w_accept ? watt_in  : r_watt;
  assign w_wr_addr   = f_wr_addr(w_idx_nxt);
  assign w_wr_data   = f_wr_data(w_idx_nxt, w_spo2_src, w_heart_src, w_watt_src);

  // Next-state, next-index, counter and flag decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx_nxt = 3'd0;
        if (upd_valid) begin
          w_accept    = 1'b1;
          w_err_nxt   = 1'b0;
          w_load      = 1'b1;
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (PSLVERROR) begin
            w_err_nxt   = 1'b1;
            w_idx_nxt   = 3'd0;
            w_state_nxt = S_IDLE;
          end else begin
            case (r_idx)
              3'd0, 3'd1, 3'd2: begin
                w_idx_nxt   = r_idx + 3'd1;
                w_load      = 1'b1;
                w_state_nxt = S_SETUP;
              end
              3'd3: begin
                w_idx_nxt = 3'd4;
                if (STB_HOLD != 32'd0) begin
                  w_cnt_nxt   = 8'd0;
                  w_state_nxt = S_HOLD;
                end else begin
                  w_load      = 1'b1;
                  w_state_nxt = S_SETUP;
                end
              end
              default: begin
                w_idx_nxt   = 3'd0;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            endcase
          end
        end else if (r_cnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_load      = 1'b1;
          w_state_nxt = S_SETUP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_idx_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, payload shadows and registered APB/handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 8'd0;
      r_spo2      <= 12'd0;
      r_heart     <= 12'd0;
      r_watt      <= 20'd0;
      r_upd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_WIDTH{1'b0}};
      r_pwdata    <= {DATA_WIDTH{1'b0}};
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_upd_ready <= (w_state_nxt == S_IDLE);
      r_psel      <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_pwrite    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      if (w_accept) begin
        r_spo2  <= spo2_in;
        r_heart <= heart_in;
        r_watt  <= watt_in;
      end
      // Address/data change only when a new SETUP starts, so they hold
      // through ACCESS and across idle/HOLD periods.
      if (w_load) begin
        r_paddr  <= w_wr_addr;
        r_pwdata <= w_wr_data;
      end
    end
  end

  assign upd_ready = r_upd_ready;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign done      = r_done;
  assign err       = r_err;

endmodule
